data_mem_bytelane: RTL and testbench

Parametrised byte-addressed, big-endian data memory for the MEM stage of the pipelined MIPS core. Supports byte/half/word loads and stores with sign or zero extension, registered one-cycle read data, alignment and range checking, and a post-reset clear sequencer that zeroes the array and stalls the pipeline while it runs. ALU result drives `address`; the EX/MEM `Read_Data_2` value drives `wdata`.

---
 rtl/data_mem_bytelane.sv | 177 +++++++++++++++++
 tb/tb_data_mem_bytelane.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bytelane.sv
// Byte-addressed big-endian data memory for the MEM stage.
// Byte/half/word loads and stores, registered read data, alignment and range
// checks, and a post-reset clear sequencer that zeroes the array while busy.
module data_mem_bytelane #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              misalign,
  output logic              range_err,
  output logic              req_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int WORDS = DEPTH / 4;
  localparam int IW    = AW - 2;

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rdata_valid_q, rdata_valid_d;
  logic            misalign_q, misalign_d;
  logic            range_err_q, range_err_d;
  logic            req_err_q, req_err_d;

  logic [31:0]     mem_q [WORDS];

  logic [1:0]      off;
  logic [IW-1:0]   addr_idx;
  logic [31:0]     rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [31:0]     load_val;
  logic [3:0]      st_be;
  logic [31:0]     st_wd;
  logic            in_range, size_bad, unaligned, idle, both;
  logic            do_store, load_ok;

  logic            mem_we;
  logic [IW-1:0]   mem_idx;
  logic [3:0]      mem_be;
  logic [31:0]     mem_wd;

  // Extend a loaded byte to 32 bits; unsigned forces zeros above bit 7.
  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic uns);
    logic signed [7:0] sb;
    sb = b;
    return uns ? {24'h0, b} : 32'(sb);
  endfunction

  // Extend a loaded halfword to 32 bits; unsigned forces zeros above bit 15.
  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic uns);
    logic signed [15:0] sh;
    sh = h;
    return uns ? {16'h0, h} : 32'(sh);
  endfunction

  // State, clear counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_CLEAR;
      cnt_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      range_err_q   <= 1'b0;
      req_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      misalign_q    <= misalign_d;
      range_err_q   <= range_err_d;
      req_err_q     <= req_err_d;
    end
  end

  // Next state: sweep every word once after reset, then stay in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IW'(WORDS - 1)) state_d = S_IDLE;
    end
  end

  // Request decode: lane selection, load extraction and store byte enables.
  always_comb begin
    off      = address[1:0];
    addr_idx = address[AW-1:2];
    rd_word  = mem_q[addr_idx];
    case (off)
      2'd0:    rd_byte = rd_word[31:24];
      2'd1:    rd_byte = rd_word[23:16];
      2'd2:    rd_byte = rd_word[15:8];
      default: rd_byte = rd_word[7:0];
    endcase
    rd_half = off[1] ? rd_word[15:0] : rd_word[31:16];
    case (size)
      2'b00:   load_val = ext_byte(rd_byte, ld_unsigned);
      2'b01:   load_val = ext_half(rd_half, ld_unsigned);
      default: load_val = rd_word;
    endcase
    case (size)
      2'b00: begin
        st_be = 4'b1000 >> off;
        st_wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_be = off[1] ? 4'b0011 : 4'b1100;
        st_wd = {2{wdata[15:0]}};
      end
      default: begin
        st_be = 4'b1111;
        st_wd = wdata;
      end
    endcase
  end

  // Output process: check priority, pulse generation and array write port.
  always_comb begin
    idle      = (state_q == S_IDLE);
    both      = mem_read & mem_write;
    in_range  = ((address >> AW) == '0);
    size_bad  = (size == 2'b11);
    unaligned = ((size == 2'b01) & address[0]) | ((size == 2'b10) & (address[1:0] != 2'b00));
    do_store  = idle & mem_write & ~size_bad & ~unaligned & in_range;
    load_ok   = idle & mem_read & ~mem_write & ~size_bad & ~unaligned;

    busy          = ~idle;
    req_err_d     = idle & both;
    misalign_d    = idle & ~both & (mem_read | mem_write) & (size_bad | unaligned);
    range_err_d   = idle & ~both & (mem_read | mem_write) & ~size_bad & ~unaligned & ~in_range;
    rdata_valid_d = load_ok;
    rdata_d       = rdata_q;
    if (load_ok) rdata_d = in_range ? load_val : 32'h0;

    mem_we  = do_store;
    mem_idx = addr_idx;
    mem_be  = st_be;
    mem_wd  = st_wd;
    if (!idle) begin
      mem_we  = 1'b1;
      mem_idx = cnt_q;
      mem_be  = 4'b1111;
      mem_wd  = 32'h0;
    end
  end

  // Array write: only enabled byte lanes change.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && mem_be[i]) mem_q[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign misalign    = misalign_q;
  assign range_err   = range_err_q;
  assign req_err     = req_err_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Self-checking bench for data_mem_bytelane (DEPTH = 64).
module tb_data_mem_bytelane;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        ld_unsigned = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rdata_valid, busy, misalign, range_err, req_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] ed;
    logic        em;
    logic        er;
    logic        eq;
  } vec_t;

  // expected {busy, rdata_valid, misalign, range_err, req_err, rdata}
  logic [36:0] sb[$];
  logic [31:0] hold = 32'h0;

  data_mem_bytelane #(.DEPTH(64), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .address(address), .mem_read(mem_read),
    .mem_write(mem_write), .size(size), .ld_unsigned(ld_unsigned), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .misalign(misalign),
    .range_err(range_err), .req_err(req_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                              input logic ev, input logic [31:0] ed,
                              input logic em, input logic er, input logic eq);
    vec_t v;
    v = '{rd: rd, wr: wr, sz: sz, uns: uns, addr: addr, wd: wd,
          ev: ev, ed: ed, em: em, er: er, eq: eq};
    return v;
  endfunction

  // Apply one request at the falling edge and queue the expected response.
  task automatic drive(input vec_t v);
    logic [31:0] er_data;
    @(negedge clk);
    mem_read    = v.rd;
    mem_write   = v.wr;
    size        = v.sz;
    ld_unsigned = v.uns;
    address     = v.addr;
    wdata       = v.wd;
    er_data     = v.ev ? v.ed : hold;
    hold        = er_data;
    sb.push_back({1'b0, v.ev, v.em, v.er, v.eq, er_data});
  endtask

  task automatic set_idle();
    mem_read = 1'b0; mem_write = 1'b0; size = 2'b00;
    ld_unsigned = 1'b0; address = '0; wdata = '0;
  endtask

  task automatic test_reset();
    vec_t v[$];
    int n;
    logic bad;
    logic [36:0] obs, exp;
    set_idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    obs = {busy, rdata_valid, misalign, range_err, req_err, rdata};
    if (obs !== {1'b1, 36'h0}) begin
      miscompares++;
      $display("FAIL reset_state got %h want %h", obs, {1'b1, 36'h0});
    end
    // Conflicting store+load held across the whole clear must be ignored.
    mem_read = 1'b1; mem_write = 1'b1; address = 32'h0; size = 2'b10; wdata = 32'hA5A5A5A5;
    reset = 1'b1;
    n = 0;
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      n++;
      if (rdata_valid | misalign | range_err | req_err | (rdata != 32'h0)) bad = 1'b1;
      @(negedge clk);
    end
    if (rdata_valid | misalign | range_err | req_err | (rdata != 32'h0)) bad = 1'b1;
    set_idle();
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL busy_cycles got %0d want 16", n);
    end
    vectors++;
    if (bad !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_quiet got %b want 0", bad);
    end
    v.push_back(mk(1, 0, 2'b10, 0, 32'h3C, 0, 1, 32'h0, 0, 0, 0));
    v.push_back(mk(1, 0, 2'b10, 0, 32'h00, 0, 1, 32'h0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {busy, rdata_valid, misalign, range_err, req_err, rdata};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL post_clear[%0d] got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_word_store_byte_loads();
    vec_t v[$];
    logic [36:0] obs, exp;
    v.push_back(mk(0, 1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 0, 2'b00, 0, 32'h08, 0, 1, 32'hFFFFFFDE, 0, 0, 0));
    v.push_back(mk(1, 0, 2'b00, 0, 32'h09, 0, 1, 32'hFFFFFFAD, 0, 0, 0));
    v.push_back(mk(1, 0, 2'b00, 0, 32'h0A, 0, 1, 32'hFFFFFFBE, 0, 0, 0));
    v.push_back(mk(1, 0, 2'b00, 0, 32'h0B, 0, 1, 32'hFFFFFFEF, 0, 0, 0));
    v.push_back(mk(1, 0, 2'b00, 1, 32'h08, 0, 1, 32'h000000DE, 0, 0, 0));
    v.push_back(mk(1, 0, 2'b01, 0, 32'h08, 0, 1, 32'hFFFFDEAD, 0, 0, 0));
    v.push_back(mk(1, 0, 2'b01, 1, 32'h0A, 0, 1, 32'h0000BEEF, 0, 0, 0));
    v.push_back(mk(1, 0, 2'b10, 1, 32'h08, 0, 1, 32'hDEADBEEF, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {busy, rdata_valid, misalign, range_err, req_err, rdata};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL word_store_loads[%0d] got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    logic [36:0] obs, exp;
    v.push_back(mk(0, 1, 2'b00, 0, 32'h0A, 32'hAABBCC25, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 0, 2'b10, 0, 32'h08, 0, 1, 32'hDEAD25EF, 0, 0, 0));
    v.push_back(mk(1, 0, 2'b01, 1, 32'h0A, 0, 1, 32'h000025EF, 0, 0, 0));
    v.push_back(mk(0, 1, 2'b01, 0, 32'h0E, 32'h1234F00D, 0, 0, 0, 0, 0));
    v.push_back(mk(1, 0, 2'b01, 0, 32'h0E, 0, 1, 32'hFFFFF00D, 0, 0, 0));
    v.push_back(mk(0, 0, 2'b00, 0, 32'h00, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {busy, rdata_valid, misalign, range_err, req_err, rdata};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_misalign();
    vec_t v[$];
    logic [36:0] obs, exp;
    v.push_back(mk(1, 0, 2'b01, 0, 32'h09, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(1, 0, 2'b10, 0, 32'h0A, 0, 0, 0, 1, 0, 0));
    v.push_back(mk(0, 1, 2'b11, 0, 32'h08, 32'hFFFFFFFF, 0, 0, 1, 0, 0));
    v.push_back(mk(0, 1, 2'b10, 0, 32'h09, 32'h0, 0, 0, 1, 0, 0));
    v.push_back(mk(1, 0, 2'b10, 0, 32'h08, 0, 1, 32'hDEAD25EF, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {busy, rdata_valid, misalign, range_err, req_err, rdata};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL misalign[%0d] got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_range();
    vec_t v[$];
    logic [36:0] obs, exp;
    v.push_back(mk(1, 0, 2'b10, 0, 32'h40, 0, 1, 32'h0, 0, 1, 0));
    v.push_back(mk(1, 0, 2'b10, 0, 32'h3C, 0, 1, 32'h0, 0, 0, 0));
    v.push_back(mk(0, 1, 2'b10, 0, 32'h10000000, 32'hCAFEF00D, 0, 0, 0, 1, 0));
    v.push_back(mk(1, 0, 2'b10, 0, 32'h00, 0, 1, 32'h0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {busy, rdata_valid, misalign, range_err, req_err, rdata};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL range[%0d] got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_req_err();
    vec_t v[$];
    logic [36:0] obs, exp;
    v.push_back(mk(1, 1, 2'b10, 0, 32'h04, 32'h12345678, 0, 0, 0, 0, 1));
    v.push_back(mk(1, 0, 2'b10, 0, 32'h04, 0, 1, 32'h12345678, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {busy, rdata_valid, misalign, range_err, req_err, rdata};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL req_err[%0d] got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    vec_t v[$];
    int n;
    logic [36:0] obs, exp;
    @(negedge clk);
    set_idle();
    reset = 1'b0;
    #1;
    hold = 32'h0;
    vectors++;
    obs = {busy, rdata_valid, misalign, range_err, req_err, rdata};
    if (obs !== {1'b1, 36'h0}) begin
      miscompares++;
      $display("FAIL async_reset got %h want %h", obs, {1'b1, 36'h0});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n !== 16) begin
      miscompares++;
      $display("FAIL restart_busy_cycles got %0d want 16", n);
    end
    v.push_back(mk(1, 0, 2'b10, 0, 32'h04, 0, 1, 32'h0, 0, 0, 0));
    v.push_back(mk(1, 0, 2'b10, 0, 32'h08, 0, 1, 32'h0, 0, 0, 0));
    foreach (v[i]) begin
      drive(v[i]);
      @(posedge clk); #1;
      exp = sb.pop_front();
      obs = {busy, rdata_valid, misalign, range_err, req_err, rdata};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL mid_clear[%0d] got %h want %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_store_byte_loads();
    test_back_to_back();
    test_misalign();
    test_range();
    test_req_err();
    test_reset_mid_clear();
    @(negedge clk);
    set_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
